// File: rtl/tpu_act_pingpong_ctrl_if.sv
// tpu_act_pingpong_ctrl_if: loader stream and activation-buffer bus of the ping-pong controller
//   ld_valid/ld_ready/ld_data/ld_last : loader vector stream
//   buf_wr_en/buf_wr_addr/buf_wr_data : buffer inactive-bank write port
//   buf_swap_banks/buf_stream_start/buf_stream_count/buf_stream_done : bank swap and stream control
//   master = controller side, slave = loader/buffer side
interface tpu_act_pingpong_ctrl_if #(
  parameter int ARRAY_SIZE = 8,
  parameter int ACT_BITS   = 16,
  parameter int MAX_K      = 256,
  parameter int ADDR_WIDTH = 16
);
  localparam int KW = $clog2(MAX_K);
  localparam int DW = ARRAY_SIZE * ACT_BITS;
  logic                  ld_valid;
  logic                  ld_ready;
  logic [DW-1:0]         ld_data;
  logic                  ld_last;
  logic                  buf_wr_en;
  logic [ADDR_WIDTH-1:0] buf_wr_addr;
  logic [DW-1:0]         buf_wr_data;
  logic                  buf_swap_banks;
  logic                  buf_stream_start;
  logic [KW-1:0]         buf_stream_count;
  logic                  buf_stream_done;
  modport master (
    input  ld_valid, ld_data, ld_last, buf_stream_done,
    output ld_ready, buf_wr_en, buf_wr_addr, buf_wr_data,
           buf_swap_banks, buf_stream_start, buf_stream_count
  );
  modport slave (
    output ld_valid, ld_data, ld_last, buf_stream_done,
    input  ld_ready, buf_wr_en, buf_wr_addr, buf_wr_data,
           buf_swap_banks, buf_stream_start, buf_stream_count
  );
endinterface

// File: rtl/tpu_act_pingpong_ctrl.sv
// tpu_act_pingpong_ctrl: fills the inactive activation bank from the loader, then swaps and streams it
//   clk, rst_n (async, active-low), run_en, err_clr : control inputs
//   bus       : loader stream + buffer write/swap/stream port (master side)
//   fill_full, busy, tile_done, tile_count, ovf_err : status
module tpu_act_pingpong_ctrl #(
  parameter int ARRAY_SIZE = 8,
  parameter int ACT_BITS   = 16,
  parameter int MAX_K      = 256,
  parameter int ADDR_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_en,
  input  logic        err_clr,
  tpu_act_pingpong_ctrl_if.master bus,
  output logic        fill_full,
  output logic        busy,
  output logic        tile_done,
  output logic [15:0] tile_count,
  output logic        ovf_err
);
  localparam int KW = $clog2(MAX_K);
  typedef enum logic [1:0] {IDLE, SWAP, START, WAIT} state_t;
  state_t            state_q, state_d;
  logic [KW-1:0]     fill_idx_q, fill_idx_d, fill_k_q, fill_k_d, count_q, count_d;
  logic              fill_full_q, fill_full_d, ovf_q, ovf_d;
  logic              swap_q, swap_d, start_q, start_d, done_q, done_d, busy_q, busy_d;
  logic              bank_q, bank_d;
  logic [15:0]       tile_count_q, tile_count_d;
  logic [ARRAY_SIZE*ACT_BITS-1:0] wr_data;
  logic              hs, close;
  always_comb begin
    hs           = bus.ld_valid & ~fill_full_q;
    close        = hs & (bus.ld_last | (fill_idx_q == KW'(MAX_K - 1)));
    fill_idx_d   = close ? '0 : hs ? fill_idx_q + KW'(1) : fill_idx_q;
    // wraps to 0 for a full MAX_K tile, which the buffer reads as MAX_K
    fill_k_d     = close ? fill_idx_q + KW'(1) : fill_k_q;
    // close cannot coincide with SWAP because fill_full holds ld_ready low
    fill_full_d  = close | (fill_full_q & (state_q != SWAP));
    ovf_d        = (close & ~bus.ld_last) | (ovf_q & ~err_clr);
    state_d      = state_q == IDLE  ? ((fill_full_q & run_en) ? SWAP : IDLE) :
                   state_q == SWAP  ? START :
                   state_q == START ? WAIT :
                   bus.buf_stream_done ? IDLE : WAIT;
    count_d      = state_q == SWAP ? fill_k_q : count_q;
    done_d       = (state_q == WAIT) & bus.buf_stream_done;
    tile_count_d = tile_count_q + {15'd0, done_d};
    swap_d       = state_d == SWAP;
    start_d      = state_d == START;
    busy_d       = state_d != IDLE;
    bank_d       = bank_q ^ (state_q == SWAP);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fill_idx_q   <= '0;
      fill_k_q     <= '0;
      count_q      <= '0;
      fill_full_q  <= 1'b0;
      ovf_q        <= 1'b0;
      swap_q       <= 1'b0;
      start_q      <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      bank_q       <= 1'b0;
      tile_count_q <= '0;
    end else begin
      state_q      <= state_d;
      fill_idx_q   <= fill_idx_d;
      fill_k_q     <= fill_k_d;
      count_q      <= count_d;
      fill_full_q  <= fill_full_d;
      ovf_q        <= ovf_d;
      swap_q       <= swap_d;
      start_q      <= start_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      bank_q       <= bank_d;
      tile_count_q <= tile_count_d;
    end
  end
  assign wr_data              = bus.ld_data;
  assign bus.ld_ready         = ~fill_full_q;
  assign bus.buf_wr_en        = hs;
  assign bus.buf_wr_addr      = ADDR_WIDTH'(fill_idx_q);
  assign bus.buf_wr_data      = wr_data;
  assign bus.buf_swap_banks   = swap_q;
  assign bus.buf_stream_start = start_q;
  assign bus.buf_stream_count = count_q;
  assign fill_full            = fill_full_q;
  assign busy                 = busy_q;
  assign tile_done            = done_q;
  assign tile_count           = tile_count_q;
  assign ovf_err              = ovf_q;
  // bank mirror tracks the buffer: it must flip on every swap, and no write may land during a swap
  a_no_wr_on_swap: assert property (@(posedge clk) disable iff (!rst_n) !(swap_q && bus.buf_wr_en));
  a_bank_toggle:   assert property (@(posedge clk) disable iff (!rst_n) swap_q |=> bank_q != $past(bank_q));
endmodule

// File: tb/tb_tpu_act_pingpong_ctrl.sv
// tb_tpu_act_pingpong_ctrl: directed bench for the activation ping-pong controller
module tb_tpu_act_pingpong_ctrl;
  logic        clk, rst_n, run_en, err_clr;
  logic        fill_full, busy, tile_done, ovf_err;
  logic [15:0] tile_count;
  int          total, passed, fails;
  tpu_act_pingpong_ctrl_if #(.ARRAY_SIZE(8), .ACT_BITS(16), .MAX_K(256), .ADDR_WIDTH(16)) bus ();
  tpu_act_pingpong_ctrl #(.ARRAY_SIZE(8), .ACT_BITS(16), .MAX_K(256), .ADDR_WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .run_en(run_en), .err_clr(err_clr), .bus(bus),
    .fill_full(fill_full), .busy(busy), .tile_done(tile_done),
    .tile_count(tile_count), .ovf_err(ovf_err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [127:0] pat(input int a);
    logic [15:0] w;
    w = 16'(a) ^ 16'hA5C3;
    return {8{w}};
  endfunction
  task automatic beat(input int a, input logic last);
    bus.ld_valid = 1'b1;
    bus.ld_last  = last;
    bus.ld_data  = pat(a);
    #1;
    chk("wr_en", 128'(bus.buf_wr_en), 128'(1));
    chk("wr_addr", 128'(bus.buf_wr_addr), 128'(a));
    chk("wr_data", bus.buf_wr_data, pat(a));
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask
  task automatic done_pulse();
    bus.buf_stream_done = 1'b1;
    tick();
    bus.buf_stream_done = 1'b0;
  endtask
  task automatic rst_chk(input string tag);
    chk({tag, "_ready"}, 128'(bus.ld_ready), 128'(1));
    chk({tag, "_wr_en"}, 128'(bus.buf_wr_en), 128'(0));
    chk({tag, "_swap"}, 128'(bus.buf_swap_banks), 128'(0));
    chk({tag, "_start"}, 128'(bus.buf_stream_start), 128'(0));
    chk({tag, "_count"}, 128'(bus.buf_stream_count), 128'(0));
    chk({tag, "_full"}, 128'(fill_full), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_tdone"}, 128'(tile_done), 128'(0));
    chk({tag, "_tcount"}, 128'(tile_count), 128'(0));
    chk({tag, "_ovf"}, 128'(ovf_err), 128'(0));
  endtask
  initial begin
    int n;
    logic [11:0] vpat;
    total = 0; passed = 0; fails = 0;
    rst_n = 1'b0; run_en = 1'b1; err_clr = 1'b0;
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0; bus.ld_data = '0; bus.buf_stream_done = 1'b0;
    tick(); tick();
    rst_chk("rst");
    rst_n = 1'b1;
    tick();
    // single 4-vector tile
    for (int i = 0; i < 4; i++) beat(i, i == 3);
    chk("t1_full", 128'(fill_full), 128'(1));
    chk("t1_ready_lo", 128'(bus.ld_ready), 128'(0));
    chk("t1_swap_c1", 128'(bus.buf_swap_banks), 128'(0));
    tick();
    chk("t1_swap_c2", 128'(bus.buf_swap_banks), 128'(1));
    chk("t1_busy", 128'(busy), 128'(1));
    tick();
    chk("t1_start_c3", 128'(bus.buf_stream_start), 128'(1));
    chk("t1_count", 128'(bus.buf_stream_count), 128'(4));
    chk("t1_ready_hi", 128'(bus.ld_ready), 128'(1));
    chk("t1_swap_off", 128'(bus.buf_swap_banks), 128'(0));
    tick();
    chk("t1_start_off", 128'(bus.buf_stream_start), 128'(0));
    chk("t1_wait_busy", 128'(busy), 128'(1));
    tick(); tick();
    chk("t1_no_tdone", 128'(tile_done), 128'(0));
    done_pulse();
    chk("t1_tdone", 128'(tile_done), 128'(1));
    chk("t1_tcount", 128'(tile_count), 128'(1));
    chk("t1_idle", 128'(busy), 128'(0));
    tick();
    chk("t1_tdone_off", 128'(tile_done), 128'(0));
    // stream-done while idle is ignored
    done_pulse();
    chk("idle_done_tdone", 128'(tile_done), 128'(0));
    tick();
    chk("idle_done_tcount", 128'(tile_count), 128'(1));
    chk("idle_done_busy", 128'(busy), 128'(0));
    // tile A (K=8) then tile B (K=3) loaded while A streams
    for (int i = 0; i < 8; i++) beat(i, i == 7);
    tick(); tick();
    chk("ta_start", 128'(bus.buf_stream_start), 128'(1));
    chk("ta_count", 128'(bus.buf_stream_count), 128'(8));
    tick();
    for (int i = 0; i < 3; i++) beat(i, i == 2);
    chk("tb_full", 128'(fill_full), 128'(1));
    chk("tb_ready_lo", 128'(bus.ld_ready), 128'(0));
    chk("tb_busy", 128'(busy), 128'(1));
    tick();
    chk("tb_no_swap_in_wait", 128'(bus.buf_swap_banks), 128'(0));
    done_pulse();
    chk("ta_tdone", 128'(tile_done), 128'(1));
    chk("ta_tcount", 128'(tile_count), 128'(2));
    chk("tb_swap_gap", 128'(bus.buf_swap_banks), 128'(0));
    chk("tb_ready_still_lo", 128'(bus.ld_ready), 128'(0));
    tick();
    chk("tb_swap", 128'(bus.buf_swap_banks), 128'(1));
    tick();
    chk("tb_start", 128'(bus.buf_stream_start), 128'(1));
    chk("tb_count", 128'(bus.buf_stream_count), 128'(3));
    chk("tb_ready_hi", 128'(bus.ld_ready), 128'(1));
    tick();
    done_pulse();
    chk("tb_tcount", 128'(tile_count), 128'(3));
    // 256 vectors without ld_last: overflow, set beats a simultaneous clear
    for (int i = 0; i < 255; i++) beat(i, 1'b0);
    chk("ovf_pre", 128'(ovf_err), 128'(0));
    chk("ovf_pre_full", 128'(fill_full), 128'(0));
    err_clr = 1'b1;
    beat(255, 1'b0);
    err_clr = 1'b0;
    chk("ovf_set_wins", 128'(ovf_err), 128'(1));
    chk("ovf_full", 128'(fill_full), 128'(1));
    tick(); tick();
    chk("ovf_start", 128'(bus.buf_stream_start), 128'(1));
    chk("ovf_count0", 128'(bus.buf_stream_count), 128'(0));
    chk("ovf_sticky", 128'(ovf_err), 128'(1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovf_clr", 128'(ovf_err), 128'(0));
    done_pulse();
    chk("ovf_tcount", 128'(tile_count), 128'(4));
    // run_en low holds a full tile
    run_en = 1'b0;
    beat(0, 1'b0);
    beat(1, 1'b1);
    chk("hold_full", 128'(fill_full), 128'(1));
    tick(); tick();
    chk("hold_no_swap", 128'(bus.buf_swap_banks), 128'(0));
    chk("hold_busy", 128'(busy), 128'(0));
    chk("hold_ready", 128'(bus.ld_ready), 128'(0));
    run_en = 1'b1;
    tick();
    chk("hold_swap", 128'(bus.buf_swap_banks), 128'(1));
    tick();
    chk("hold_start", 128'(bus.buf_stream_start), 128'(1));
    chk("hold_count", 128'(bus.buf_stream_count), 128'(2));
    tick();
    // reset during WAIT with a half-loaded tile
    beat(0, 1'b0);
    beat(1, 1'b0);
    chk("pre_rst_busy", 128'(busy), 128'(1));
    rst_n = 1'b0;
    #1;
    rst_chk("mid_rst");
    tick();
    rst_n = 1'b1;
    tick();
    beat(0, 1'b1);
    chk("one_full", 128'(fill_full), 128'(1));
    tick();
    chk("one_swap", 128'(bus.buf_swap_banks), 128'(1));
    tick();
    chk("one_start", 128'(bus.buf_stream_start), 128'(1));
    chk("one_count", 128'(bus.buf_stream_count), 128'(1));
    tick();
    done_pulse();
    chk("one_tcount", 128'(tile_count), 128'(1));
    // stalled loader, K=5
    vpat = 12'b1011_0010_1101;
    n = 0;
    for (int j = 0; j < 12 && n < 5; j++) begin
      bus.ld_valid = vpat[j];
      bus.ld_last  = (n == 4);
      bus.ld_data  = pat(n);
      #1;
      chk("stall_wr_en", 128'(bus.buf_wr_en), 128'(vpat[j]));
      if (vpat[j]) chk("stall_addr", 128'(bus.buf_wr_addr), 128'(n));
      tick();
      if (vpat[j]) n++;
    end
    chk("stall_writes", 128'(n), 128'(5));
    bus.ld_valid = 1'b1;
    bus.ld_last  = 1'b0;
    #1;
    chk("stall_blocked_c1", 128'(bus.buf_wr_en), 128'(0));
    chk("stall_ready_lo", 128'(bus.ld_ready), 128'(0));
    tick();
    chk("stall_blocked_c2", 128'(bus.buf_wr_en), 128'(0));
    chk("stall_swap", 128'(bus.buf_swap_banks), 128'(1));
    bus.ld_valid = 1'b0;
    tick();
    chk("stall_start", 128'(bus.buf_stream_start), 128'(1));
    chk("stall_count", 128'(bus.buf_stream_count), 128'(5));
    tick();
    done_pulse();
    chk("stall_tcount", 128'(tile_count), 128'(2));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/tpu_act_pingpong_ctrl.md
# tpu_act_pingpong_ctrl

Sequencing controller for the TPU activation ping-pong buffer. It accepts activation tiles from the loader as a valid/ready vector stream and writes each tile into the buffer's inactive bank. Once the active bank has finished streaming, it swaps banks and starts a stream of the stored tile length into the systolic array. Loading tile N+1 therefore overlaps streaming tile N.

## Interface

Parameters:
- ARRAY_SIZE, 8, lanes per activation vector
- ACT_BITS, 16, bits per lane
- MAX_K, 256, buffer depth in vectors, power of two; KW = $clog2(MAX_K)
- ADDR_WIDTH, 16, buffer write-address width, ≥ KW

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low; shared with the buffer
- run_en  in  1  allow new swap/stream sequences
- ld_valid  in  1  loader vector valid
- ld_ready  out  1  controller accepts vector
- ld_data  in  ARRAY_SIZE*ACT_BITS  activation vector
- ld_last  in  1  final vector of tile
- buf_wr_en  out  1  buffer write strobe
- buf_wr_addr  out  ADDR_WIDTH  buffer write address
- buf_wr_data  out  ARRAY_SIZE*ACT_BITS  buffer write data
- buf_swap_banks  out  1  one-cycle swap pulse
- buf_stream_start  out  1  one-cycle stream start pulse
- buf_stream_count  out  KW  vectors to stream
- buf_stream_done  in  1  buffer stream-done pulse
- fill_full  out  1  inactive bank holds a complete, unstreamed tile
- busy  out  1  stream FSM not idle
- tile_done  out  1  one-cycle pulse per completed stream
- tile_count  out  16  completed streams, wraps
- ovf_err  out  1  sticky: tile exceeded MAX_K vectors
- err_clr  in  1  clears ovf_err

## Operation

Fill side:
- fill_idx (KW bits) is the write pointer.
- ld_ready = !fill_full.
- On a handshake (ld_valid & ld_ready):
  - buf_wr_en=1, buf_wr_addr=zero-extended fill_idx, buf_wr_data=ld_data. These three are combinational from the handshake.
  - fill_idx increments.
- If ld_last, or fill_idx==MAX_K-1, the tile closes:
  - fill_full←1.
  - fill_k←fill_idx+1, taken mod MAX_K; the value 0 encodes MAX_K.
  - fill_idx←0.
- If the tile closes at fill_idx==MAX_K-1 without ld_last, ovf_err←1. Subsequent beats up to and including ld_last start a new tile; the loader is responsible for the resulting misframing.

Stream FSM:
- IDLE→SWAP when fill_full & run_en.
- SWAP→START unconditionally.
  - buf_swap_banks=1 during SWAP.
  - fill_full clears at the SWAP→START edge, and buf_stream_count←fill_k is registered on that same edge.
- START→WAIT unconditionally. buf_stream_start=1 during START.
- WAIT→IDLE on buf_stream_done.
  - tile_done pulses the cycle after buf_stream_done.
  - tile_count increments on that same edge.
- busy = (state != IDLE).
- The controller mirrors the buffer's active bank internally only for checking. It resets to 0 and toggles on each swap; writes always target the buffer's inactive bank.
- run_en low blocks only IDLE→SWAP. A sequence already in flight completes.
- err_clr clears ovf_err. If err_clr and a new overflow occur in the same cycle, set wins.

## Timing

- Reset values:
  - All outputs 0 except ld_ready=1.
  - FSM=IDLE, fill_idx=0, fill_k=0, tile_count=0, ovf_err=0.
- Reset mid-operation aborts everything. The buffer resets in the same cycle, so the bank mirrors stay consistent; partially written data is discarded.
- Latency, taking the last-beat handshake in cycle c, FSM idle and run_en=1:
  - c+1: fill_full=1.
  - c+2: swap pulse.
  - c+3: start pulse; ld_ready=1 again, writing the newly inactive bank.
  - c+4: WAIT.
- A swap never coincides with a write: fill_full=1 forces ld_ready=0 through SWAP.
- When WAIT→IDLE occurs with fill_full already set, SWAP follows immediately, so the back-to-back gap between streams is 3 cycles.
- A tile that closes while a stream is running holds ld_ready=0 until its own SWAP has passed.
- buf_stream_done outside WAIT is ignored.
- Single-vector tiles are legal: buf_stream_count=1.

## Test plan

- Load 4 vectors (ld_last on the 4th), run_en=1 -> 4 writes at addr 0..3; swap at c+2; start at c+3 with count=4; tile_done one cycle after buf_stream_done; tile_count=1.
- Load tile A (K=8), then tile B (K=3) while A streams -> B is written during A's WAIT; ld_ready=0 after B closes; B's swap is issued the cycle after A's WAIT exits; B streams with count=3.
- Load 256 vectors without ld_last (MAX_K=256) -> tile closes at index 255; buf_stream_count=0; ovf_err=1; err_clr then clears it.
- Full tile with run_en=0 -> fill_full=1, busy=0, no swap; raising run_en gives a swap 1 cycle later.
- Reset asserted during WAIT with a second tile half-loaded -> all outputs at reset values; the next tile writes from addr 0.
- Stalled loader (random ld_valid gaps), K=5 -> exactly 5 writes with contiguous addresses 0..4 and no writes while ld_ready=0.
